// File: rtl/seg_display_reader_if.sv
// Bus bundle for the 7-segment display monitor: the observed display lines
// plus the captured per-digit results read back by the register block.
interface seg_display_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   pattern_err;
    logic                    update;
    logic [2:0]              update_idx;

    modport master (
        output seg_n, an_n, clear,
        input  digits, digit_valid, digit_blank, pattern_err, update, update_idx
    );

    modport slave (
        input  seg_n, an_n, clear,
        output digits, digit_valid, digit_blank, pattern_err, update, update_idx
    );
endinterface

// File: rtl/seg_display_reader.sv
// Passive monitor of a multiplexed active-low 7-segment bus: recovers the hex
// nibble on each digit once the bus has held one tuple for STABLE_CYCLES samples.
module seg_display_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                 HCLK,
    input logic                 HRESET,
    seg_display_reader_if.slave bus
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int               TUP_W   = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Returns {recognised, nibble}; segment order is A..G with A in bit 6.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0001100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    logic [6:0]              seg_n_p1, seg_n_p2;
    logic [NUM_DIGITS-1:0]   an_n_p1, an_n_p2;
    logic [TUP_W-1:0]        tup_p2, tup_p3;
    logic [CNT_W-1:0]        cnt_p3, cnt_nxt;
    logic                    armed_p3, armed_nxt;
    logic                    changed, run_done;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    one_sel, capture;
    logic [2:0]              cap_idx;
    logic [4:0]              dec;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q, blank_q, err_q;
    logic                    update_q;
    logic [2:0]              update_idx_q;

    // Stages p1/p2: two-flop synchroniser on the asynchronous display lines
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            seg_n_p1 <= '1;
            seg_n_p2 <= '1;
            an_n_p1  <= '1;
            an_n_p2  <= '1;
        end else begin
            seg_n_p1 <= bus.seg_n;
            seg_n_p2 <= seg_n_p1;
            an_n_p1  <= bus.an_n;
            an_n_p2  <= an_n_p1;
        end
    end

    always_comb begin
        tup_p2    = {an_n_p2, seg_n_p2};
        changed   = (tup_p2 != tup_p3);
        cnt_nxt   = changed ? CNT_W'(1) : sat_inc(cnt_p3);
        armed_nxt = changed | armed_p3;
        run_done  = armed_nxt && (cnt_nxt == CNT_MAX);
        sel       = ~an_n_p2;
        one_sel   = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        capture   = run_done && one_sel;
        cap_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_n_p2[i]) cap_idx = 3'(i);
        end
        dec = decode_seg(seg_n_p2);
    end

    // Stage p3: previous tuple and stability run tracking
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tup_p3   <= '1;
            cnt_p3   <= '0;
            armed_p3 <= 1'b1;
        end else begin
            tup_p3   <= tup_p2;
            cnt_p3   <= cnt_nxt;
            armed_p3 <= armed_nxt & ~run_done;
        end
    end

    // Capture stage: per-digit value and status storage; capture overrides clear
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            digits_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            err_q        <= '0;
            update_q     <= 1'b0;
            update_idx_q <= '0;
        end else begin
            update_q <= capture;
            if (capture) update_idx_q <= cap_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.clear) begin
                    valid_q[i] <= 1'b0;
                    blank_q[i] <= 1'b0;
                    err_q[i]   <= 1'b0;
                end
                if (capture && (cap_idx == 3'(i))) begin
                    if (dec[4]) begin
                        digits_q[4*i +: 4] <= dec[3:0];
                        valid_q[i]         <= 1'b1;
                        blank_q[i]         <= 1'b0;
                        err_q[i]           <= 1'b0;
                    end else if (seg_n_p2 == 7'h7F) begin
                        valid_q[i] <= 1'b0;
                        blank_q[i] <= 1'b1;
                        err_q[i]   <= 1'b0;
                    end else begin
                        valid_q[i] <= 1'b0;
                        blank_q[i] <= 1'b0;
                        err_q[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.digit_blank = blank_q;
    assign bus.pattern_err = err_q;
    assign bus.update      = update_q;
    assign bus.update_idx  = update_idx_q;
endmodule

// File: tb/tb_seg_display_reader.sv
// Bench for seg_display_reader: directed vector table, hand-written corner
// sequences and random bus traffic compared against a run-length reference model.
module tb_seg_display_reader;
    localparam int          ND   = 4;
    localparam int          SC   = 4;
    localparam logic [10:0] ONES = '1;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    seg_display_reader_if #(.NUM_DIGITS(ND)) bus();

    seg_display_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] pat_tbl [16];

    // reference model state
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_blank, m_err;
    logic        m_upd;
    logic [2:0]  m_idx;
    logic [10:0] pipe [$];
    logic [10:0] lhist [$];

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        clr;
        int          hold;
        logic [15:0] e_dig;
        logic [3:0]  e_val;
        logic [3:0]  e_blk;
        logic [3:0]  e_err;
        int          e_pulses;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return {bus.digits, bus.digit_valid, bus.digit_blank, bus.pattern_err,
                bus.update, bus.update_idx};
    endfunction

    function automatic logic [31:0] model_pack();
        return {m_digits, m_valid, m_blank, m_err, m_upd, m_idx};
    endfunction

    task automatic model_reset();
        m_digits = '0; m_valid = '0; m_blank = '0; m_err = '0;
        m_upd = 1'b0; m_idx = '0;
        pipe.delete();
        pipe.push_back(ONES);
        pipe.push_back(ONES);
        lhist.delete();
    endtask

    // One clock edge: the logic sees the tuple driven two edges earlier; a capture
    // happens when the current run of identical tuples is exactly SC long.
    task automatic model_edge();
        logic [10:0] t;
        int run, nz, di, found;
        if (HRESET) begin
            model_reset();
            return;
        end
        t = pipe.pop_front();
        pipe.push_back({bus.an_n, bus.seg_n});
        lhist.push_back(t);
        if (lhist.size() > SC + 1) void'(lhist.pop_front());
        run = 0;
        for (int k = lhist.size() - 1; k >= 0; k--) begin
            if (lhist[k] != t) break;
            run++;
        end
        nz = 0; di = 0;
        for (int i = 0; i < ND; i++) if (!t[7+i]) begin nz++; di = i; end
        m_upd = 1'b0;
        if (bus.clear) begin m_valid = '0; m_blank = '0; m_err = '0; end
        if (run == SC && nz == 1) begin
            m_upd = 1'b1;
            m_idx = 3'(di);
            found = -1;
            for (int p = 0; p < 16; p++) if (pat_tbl[p] == t[6:0]) found = p;
            m_valid[di] = 1'b0; m_blank[di] = 1'b0; m_err[di] = 1'b0;
            if (found >= 0) begin
                m_digits[4*di +: 4] = 4'(found);
                m_valid[di] = 1'b1;
            end else if (t[6:0] == 7'h7F) begin
                m_blank[di] = 1'b1;
            end else begin
                m_err[di] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #1;
        chk("model_cycle", dut_pack(), model_pack());
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] an, input logic clr);
        bus.seg_n = seg;
        bus.an_n  = an;
        bus.clear = clr;
    endtask

    initial begin
        int pulses;
        logic [3:0] a;
        logic [6:0] s;
        int r, hold;

        pat_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        tbl[0] = '{7'b0010010, 4'b1110, 1'b0, 10, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 1};
        tbl[1] = '{7'b0000110, 4'b1110, 1'b0,  8, 16'h0003, 4'b0001, 4'b0000, 4'b0000, 1};
        tbl[2] = '{7'b0001000, 4'b1101, 1'b0,  8, 16'h00A3, 4'b0011, 4'b0000, 4'b0000, 1};
        tbl[3] = '{7'b1100000, 4'b1011, 1'b0,  8, 16'h0BA3, 4'b0111, 4'b0000, 4'b0000, 1};
        tbl[4] = '{7'b0111000, 4'b0111, 1'b0,  8, 16'hFBA3, 4'b1111, 4'b0000, 4'b0000, 1};
        tbl[5] = '{7'b0000000, 4'b1100, 1'b0, 10, 16'hFBA3, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[6] = '{7'b0000000, 4'b1111, 1'b0, 10, 16'hFBA3, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[7] = '{7'b1010101, 4'b1101, 1'b0,  8, 16'hFBA3, 4'b1101, 4'b0000, 4'b0010, 1};
        tbl[8] = '{7'b1111111, 4'b1101, 1'b0,  8, 16'hFBA3, 4'b1101, 4'b0010, 4'b0000, 1};
        tbl[9] = '{7'b1111111, 4'b1111, 1'b1,  3, 16'hFBA3, 4'b0000, 4'b0000, 4'b0000, 0};

        model_reset();
        drive(7'h7F, 4'hF, 1'b0);
        HRESET = 1'b1;
        tick();
        tick();
        chk("reset_state", dut_pack(), 32'h0);
        HRESET = 1'b0;

        // single digit: update exactly on the sixth edge after the change
        drive(7'b0010010, 4'b1110, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("seqA_update", {31'b0, bus.update}, {31'b0, (k == 6)});
        end
        chk("seqA_digit0", {28'b0, bus.digits[3:0]}, 32'h2);
        chk("seqA_valid", {28'b0, bus.digit_valid}, 32'h1);

        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;

        for (int v = 0; v < 10; v++) begin
            drive(tbl[v].seg, tbl[v].an, tbl[v].clr);
            pulses = 0;
            for (int c = 0; c < tbl[v].hold; c++) begin
                tick();
                if (bus.update) pulses++;
            end
            bus.clear = 1'b0;
            chk("tbl_digits", {16'b0, bus.digits}, {16'b0, tbl[v].e_dig});
            chk("tbl_flags", {20'b0, bus.digit_valid, bus.digit_blank, bus.pattern_err},
                {20'b0, tbl[v].e_val, tbl[v].e_blk, tbl[v].e_err});
            chk("tbl_pulses", 32'(pulses), 32'(tbl[v].e_pulses));
        end

        // glitch: a 3-cycle pattern must not be captured, its successor must
        pulses = 0;
        drive(7'b0100100, 4'b1110, 1'b0);
        for (int c = 0; c < 3; c++) begin tick(); if (bus.update) pulses++; end
        drive(7'b0001111, 4'b1110, 1'b0);
        for (int c = 0; c < 8; c++) begin tick(); if (bus.update) pulses++; end
        chk("glitch_pulses", 32'(pulses), 32'd1);
        chk("glitch_digit0", {28'b0, bus.digits[3:0]}, 32'h7);

        // reset in the middle of a stable run
        drive(7'b0001100, 4'b1110, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        HRESET = 1'b1;
        tick();
        chk("midreset_state", dut_pack(), 32'h0);
        HRESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("midreset_update", {31'b0, bus.update}, {31'b0, (k == 6)});
        end
        chk("midreset_digit0", {28'b0, bus.digits[3:0]}, 32'h9);

        // random traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = 4'hF;
            if (r < 4) a[r] = 1'b0;
            else if (r == 5) a = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            if (r < 16) s = pat_tbl[r];
            else if (r == 16) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 8);
            drive(s, a, ($urandom_range(0, 15) == 0));
            HRESET = ($urandom_range(0, 40) == 0);
            tick();
            HRESET = 1'b0;
            bus.clear = 1'b0;
            for (int c = 1; c < hold; c++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
